// File: rtl/vrf_rd_bank_arb.sv
// vrf_rd_bank_arb: arbitrates 5 vector-issue read ports onto the 4-bank uVRF.
// Each bank serves up to two distinct rows per cycle with round-robin priority;
// requests for an already-slotted row merge onto that slot. Grants are
// registered into a one-stage read pipe that drives bank addresses and
// read-data steering.
module vrf_rd_bank_arb #(
  parameter int RPORT_NUM  = 5,
  parameter int BANK_NUM   = 4,
  parameter int BANK_RPORT = 2,
  parameter int ADDR_W     = 6,
  parameter int ROW_W      = 4,
  parameter int RS_W       = 16,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [RPORT_NUM-1:0]                 req_vld,
  input  logic [RPORT_NUM*ADDR_W-1:0]          req_vaddr,
  input  logic [RPORT_NUM*RS_W-1:0]            req_rs_idx,
  input  logic [RPORT_NUM*2-1:0]               req_rs_field_idx,
  output logic [RPORT_NUM-1:0]                 req_rdy,
  output logic [BANK_NUM*BANK_RPORT-1:0]       bank_rd_en,
  output logic [BANK_NUM*BANK_RPORT*ROW_W-1:0] bank_rd_row,
  output logic [RPORT_NUM-1:0]                 pipe_vld,
  output logic [RPORT_NUM*ADDR_W-1:0]          pipe_vaddr,
  output logic [RPORT_NUM*RS_W-1:0]            pipe_rs_idx,
  output logic [RPORT_NUM*2-1:0]               pipe_rs_field_idx,
  output logic [RPORT_NUM*2-1:0]               pipe_bank,
  output logic [RPORT_NUM-1:0]                 pipe_slot,
  output logic [CNT_W-1:0]                     conflict_cnt
);

  localparam int SLOT_NUM = BANK_NUM * BANK_RPORT;

  logic [ADDR_W-1:0] vaddr_a [RPORT_NUM];
  logic [1:0]        bank_a  [RPORT_NUM];
  logic [ROW_W-1:0]  row_a   [RPORT_NUM];

  logic [2:0] rr_ptr_q [BANK_NUM];
  logic [2:0] rr_ptr_d [BANK_NUM];

  logic [RPORT_NUM-1:0] grant;
  logic [RPORT_NUM-1:0] gslot;
  logic [SLOT_NUM-1:0]  slot_used;
  logic [ROW_W-1:0]     slot_row [SLOT_NUM];
  logic [3:0]           scan_sum;
  logic [2:0]           scan_idx;
  logic                 deny;

  logic [SLOT_NUM-1:0]          bank_rd_en_q, bank_rd_en_d;
  logic [SLOT_NUM*ROW_W-1:0]    bank_rd_row_q, bank_rd_row_d;
  logic [RPORT_NUM-1:0]         pipe_vld_q, pipe_vld_d;
  logic [RPORT_NUM*ADDR_W-1:0]  pipe_vaddr_q, pipe_vaddr_d;
  logic [RPORT_NUM*RS_W-1:0]    pipe_rs_idx_q, pipe_rs_idx_d;
  logic [RPORT_NUM*2-1:0]       pipe_field_q, pipe_field_d;
  logic [RPORT_NUM*2-1:0]       pipe_bank_q, pipe_bank_d;
  logic [RPORT_NUM-1:0]         pipe_slot_q, pipe_slot_d;
  logic [CNT_W-1:0]             conflict_cnt_q, conflict_cnt_d;

  // Decode each port's address into bank {vreg[4], partial} and row vreg[3:0].
  always_comb begin
    for (int p = 0; p < RPORT_NUM; p++) begin
      vaddr_a[p] = req_vaddr[p*ADDR_W +: ADDR_W];
      bank_a[p]  = {vaddr_a[p][5], vaddr_a[p][0]};
      row_a[p]   = vaddr_a[p][4:1];
    end
  end

  // Per-bank round-robin scan: two distinct rows get slots, equal rows merge.
  always_comb begin
    grant     = '0;
    gslot     = '0;
    slot_used = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < SLOT_NUM; i++) slot_row[i] = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      rr_ptr_d[b] = rr_ptr_q[b];
      for (int k = 0; k < RPORT_NUM; k++) begin
        scan_sum = {1'b0, rr_ptr_q[b]} + 4'(k);
        scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
        if (req_vld[scan_idx] && !flush && !rst && bank_a[scan_idx] == 2'(b)) begin
          if (!slot_used[b*2]) begin
            slot_used[b*2]   = 1'b1;
            slot_row[b*2]    = row_a[scan_idx];
            grant[scan_idx]  = 1'b1;
            rr_ptr_d[b]      = (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
          end else if (row_a[scan_idx] == slot_row[b*2]) begin
            grant[scan_idx]  = 1'b1;
          end else if (!slot_used[b*2+1]) begin
            slot_used[b*2+1] = 1'b1;
            slot_row[b*2+1]  = row_a[scan_idx];
            grant[scan_idx]  = 1'b1;
            gslot[scan_idx]  = 1'b1;
            rr_ptr_d[b]      = (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
          end else if (row_a[scan_idx] == slot_row[b*2+1]) begin
            grant[scan_idx]  = 1'b1;
            gslot[scan_idx]  = 1'b1;
          end
        end
      end
    end
  end

  // Next pipe-stage contents; ungranted fields and unused slots hold.
  always_comb begin
    deny          = |(req_vld & ~grant) && !flush;
    pipe_vld_d    = grant;
    bank_rd_en_d  = slot_used;
    bank_rd_row_d = bank_rd_row_q;
    pipe_vaddr_d  = pipe_vaddr_q;
    pipe_rs_idx_d = pipe_rs_idx_q;
    pipe_field_d  = pipe_field_q;
    pipe_bank_d   = pipe_bank_q;
    pipe_slot_d   = pipe_slot_q;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (slot_used[i]) bank_rd_row_d[i*ROW_W +: ROW_W] = slot_row[i];
    end
    for (int p = 0; p < RPORT_NUM; p++) begin
      if (grant[p]) begin
        pipe_vaddr_d[p*ADDR_W +: ADDR_W] = vaddr_a[p];
        pipe_rs_idx_d[p*RS_W +: RS_W]    = req_rs_idx[p*RS_W +: RS_W];
        pipe_field_d[p*2 +: 2]           = req_rs_field_idx[p*2 +: 2];
        pipe_bank_d[p*2 +: 2]            = bank_a[p];
        pipe_slot_d[p]                   = gslot[p];
      end
    end
    conflict_cnt_d = (deny && conflict_cnt_q != '1) ? conflict_cnt_q + 1'b1 : conflict_cnt_q;
  end

  // Pointer, pipe stage and conflict counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANK_NUM; b++) rr_ptr_q[b] <= '0;
      bank_rd_en_q   <= '0;
      bank_rd_row_q  <= '0;
      pipe_vld_q     <= '0;
      pipe_vaddr_q   <= '0;
      pipe_rs_idx_q  <= '0;
      pipe_field_q   <= '0;
      pipe_bank_q    <= '0;
      pipe_slot_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) rr_ptr_q[b] <= rr_ptr_d[b];
      bank_rd_en_q   <= bank_rd_en_d;
      bank_rd_row_q  <= bank_rd_row_d;
      pipe_vld_q     <= pipe_vld_d;
      pipe_vaddr_q   <= pipe_vaddr_d;
      pipe_rs_idx_q  <= pipe_rs_idx_d;
      pipe_field_q   <= pipe_field_d;
      pipe_bank_q    <= pipe_bank_d;
      pipe_slot_q    <= pipe_slot_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign req_rdy           = grant;
  assign bank_rd_en        = bank_rd_en_q;
  assign bank_rd_row       = bank_rd_row_q;
  assign pipe_vld          = pipe_vld_q;
  assign pipe_vaddr        = pipe_vaddr_q;
  assign pipe_rs_idx       = pipe_rs_idx_q;
  assign pipe_rs_field_idx = pipe_field_q;
  assign pipe_bank         = pipe_bank_q;
  assign pipe_slot         = pipe_slot_q;
  assign conflict_cnt      = conflict_cnt_q;

endmodule

// File: tb/tb_vrf_rd_bank_arb.sv
// Directed bench for vrf_rd_bank_arb with hand-computed expected values.
module tb_vrf_rd_bank_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [4:0]  req_vld;
  logic [29:0] req_vaddr;
  logic [79:0] req_rs_idx;
  logic [9:0]  req_rs_field_idx;
  logic [4:0]  req_rdy;
  logic [7:0]  bank_rd_en;
  logic [31:0] bank_rd_row;
  logic [4:0]  pipe_vld;
  logic [29:0] pipe_vaddr;
  logic [79:0] pipe_rs_idx;
  logic [9:0]  pipe_rs_field_idx;
  logic [9:0]  pipe_bank;
  logic [4:0]  pipe_slot;
  logic [15:0] conflict_cnt;

  int errors = 0;
  int checks = 0;

  vrf_rd_bank_arb dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .req_vld          (req_vld),
    .req_vaddr        (req_vaddr),
    .req_rs_idx       (req_rs_idx),
    .req_rs_field_idx (req_rs_field_idx),
    .req_rdy          (req_rdy),
    .bank_rd_en       (bank_rd_en),
    .bank_rd_row      (bank_rd_row),
    .pipe_vld         (pipe_vld),
    .pipe_vaddr       (pipe_vaddr),
    .pipe_rs_idx      (pipe_rs_idx),
    .pipe_rs_field_idx(pipe_rs_field_idx),
    .pipe_bank        (pipe_bank),
    .pipe_slot        (pipe_slot),
    .conflict_cnt     (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [5:0] a0, a1, a2, a3, a4);
    req_vaddr = {a4, a3, a2, a1, a0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_vld = 5'h1F;
    set_addr(6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    req_rs_idx = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_rs_field_idx = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    #2;
    chk("rst_rdy", req_rdy, 5'h00);
    chk("rst_pipe_vld", pipe_vld, 5'h00);
    chk("rst_en", bank_rd_en, 8'h00);
    chk("rst_row", bank_rd_row, 32'h0);
    chk("rst_cnt", conflict_cnt, 16'h0);
    tick;
    tick;
    rst = 1'b0;

    // One request per bank except bank0 which gets two distinct rows
    set_addr(6'h00, 6'h01, 6'h20, 6'h21, 6'h02);
    #1 chk("t1_rdy", req_rdy, 5'h1F);
    tick;
    chk("t1_vld", pipe_vld, 5'h1F);
    chk("t1_en", bank_rd_en, 8'h57);
    chk("t1_row", bank_rd_row, 32'h0000_0010);
    chk("t1_bank", pipe_bank, 10'h0E4);
    chk("t1_slot", pipe_slot, 5'h10);
    chk("t1_vaddr", pipe_vaddr, {6'h02, 6'h21, 6'h20, 6'h01, 6'h00});
    chk("t1_rs", pipe_rs_idx, {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000});
    chk("t1_fld", pipe_rs_field_idx, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
    chk("t1_cnt", conflict_cnt, 16'h0);

    // Five distinct rows on bank0: served over three cycles
    set_addr(6'h00, 6'h02, 6'h04, 6'h06, 6'h08);
    req_vld = 5'h1F;
    #1 chk("t2a_rdy", req_rdy, 5'h03);
    tick;
    chk("t2a_cnt", conflict_cnt, 16'd1);
    chk("t2a_vld", pipe_vld, 5'h03);
    chk("t2a_en", bank_rd_en, 8'h03);
    chk("t2a_row", bank_rd_row, 32'h0000_0010);
    req_vld = 5'h1C;
    #1 chk("t2b_rdy", req_rdy, 5'h0C);
    tick;
    chk("t2b_cnt", conflict_cnt, 16'd2);
    chk("t2b_vld", pipe_vld, 5'h0C);
    chk("t2b_row", bank_rd_row, 32'h0000_0032);
    req_vld = 5'h10;
    #1 chk("t2c_rdy", req_rdy, 5'h10);
    tick;
    chk("t2c_cnt", conflict_cnt, 16'd2);
    chk("t2c_vld", pipe_vld, 5'h10);
    chk("t2c_en", bank_rd_en, 8'h01);
    chk("t2c_row", bank_rd_row, 32'h0000_0034);
    chk("t2c_slot", pipe_slot[4], 1'b0);
    req_vld = 5'h00;
    #1 chk("idle_rdy", req_rdy, 5'h00);
    tick;
    chk("idle_vld", pipe_vld, 5'h00);
    chk("idle_en", bank_rd_en, 8'h00);

    // All ports read the same address: one slot, full merge
    set_addr(6'h0A, 6'h0A, 6'h0A, 6'h0A, 6'h0A);
    req_vld = 5'h1F;
    #1 chk("t3_rdy", req_rdy, 5'h1F);
    tick;
    chk("t3_vld", pipe_vld, 5'h1F);
    chk("t3_en", bank_rd_en, 8'h01);
    chk("t3_row", bank_rd_row, 32'h0000_0035);
    chk("t3_slot", pipe_slot, 5'h00);
    chk("t3_bank", pipe_bank, 10'h000);

    // Pointer now 1 for bank0: p1, p2 win, p0 denied
    set_addr(6'h00, 6'h02, 6'h04, 6'h00, 6'h00);
    req_vld = 5'h07;
    #1 chk("t3p_rdy", req_rdy, 5'h06);
    tick;
    chk("t3p_cnt", conflict_cnt, 16'd3);
    req_vld = 5'h10;
    #1 chk("t3q_rdy", req_rdy, 5'h10);
    tick;

    // Merge of p0/p2 on slot0 with pointer back at 0
    set_addr(6'h00, 6'h02, 6'h00, 6'h00, 6'h00);
    req_vld = 5'h07;
    #1 chk("t4_rdy", req_rdy, 5'h07);
    tick;
    chk("t4_vld", pipe_vld, 5'h07);
    chk("t4_slot", pipe_slot, 5'h02);
    chk("t4_en", bank_rd_en, 8'h03);
    chk("t4_row", bank_rd_row, 32'h0000_0010);
    chk("t4_cnt", conflict_cnt, 16'd3);

    // Contended traffic with flush in the second cycle
    set_addr(6'h00, 6'h02, 6'h04, 6'h06, 6'h08);
    req_vld = 5'h1F;
    #1 chk("t5a_rdy", req_rdy, 5'h0C);
    tick;
    chk("t5a_cnt", conflict_cnt, 16'd4);
    chk("t5a_vld", pipe_vld, 5'h0C);
    req_vld = 5'h13;
    flush = 1'b1;
    #1 chk("t5b_rdy", req_rdy, 5'h00);
    tick;
    chk("t5b_vld", pipe_vld, 5'h00);
    chk("t5b_en", bank_rd_en, 8'h00);
    chk("t5b_cnt", conflict_cnt, 16'd4);
    chk("t5b_row", bank_rd_row, 32'h0000_0032);
    flush = 1'b0;
    #1 chk("t5c_rdy", req_rdy, 5'h11);
    tick;
    chk("t5c_cnt", conflict_cnt, 16'd5);
    chk("t5c_slot", pipe_slot & 5'h11, 5'h01);
    chk("t5c_en", bank_rd_en, 8'h03);
    chk("t5c_row", bank_rd_row, 32'h0000_0004);

    // Asynchronous reset with grants in flight
    set_addr(6'h00, 6'h02, 6'h04, 6'h00, 6'h00);
    req_vld = 5'h02;
    #1 chk("t6a_rdy", req_rdy, 5'h02);
    tick;
    chk("t6a_vld", pipe_vld, 5'h02);
    req_vld = 5'h07;
    #1 chk("t6b_rdy", req_rdy, 5'h05);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_vld", pipe_vld, 5'h00);
    chk("t6_rst_en", bank_rd_en, 8'h00);
    chk("t6_rst_cnt", conflict_cnt, 16'h0);
    chk("t6_rst_row", bank_rd_row, 32'h0);
    chk("t6_rst_rdy", req_rdy, 5'h00);
    tick;
    rst = 1'b0;
    #1 chk("t6c_rdy", req_rdy, 5'h03);
    tick;
    chk("t6c_vld", pipe_vld, 5'h03);
    chk("t6c_cnt", conflict_cnt, 16'd1);
    chk("t6c_slot", pipe_slot & 5'h03, 5'h02);

    req_vld = 5'h00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vrf_rd_bank_arb.md
Name: vrf_rd_bank_arb

Overview:
- Arbitrates the 5 vector-issue read ports onto the 4-bank uVRF (2 x-banks by 2 y-banks, 16 rows each, 2 read ports per bank).
- Each cycle it grants up to 2 distinct rows per bank, using per-bank round-robin priority.
- Same-address requests to one bank merge onto a single bank port.
- Grant results are registered into a read pipeline stage that drives the bank read addresses and the read-data steering selects.

Parameters:
- RPORT_NUM, 5, requesting read ports.
- BANK_NUM, 4, number of banks (= BANK_X_SIZE*BANK_Y_SIZE).
- BANK_RPORT, 2, read ports per bank.
- ADDR_W, 6, uVRF address width {vreg[4:0], partial[0]}.
- ROW_W, 4, per-bank row address width.
- RS_W, 16, rs_idx width (VSB_ENT_NUM).
- CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  kill all in-flight and current grants.
- req_vld  in  RPORT_NUM  read request valid per port.
- req_vaddr  in  RPORT_NUM*ADDR_W  uVRF address per port.
- req_rs_idx  in  RPORT_NUM*RS_W  issue-entry tag per port.
- req_rs_field_idx  in  RPORT_NUM*2  operand field per port.
- req_rdy  out  RPORT_NUM  grant this cycle; request is consumed.
- bank_rd_en  out  BANK_NUM*BANK_RPORT  registered bank port enable.
- bank_rd_row  out  BANK_NUM*BANK_RPORT*ROW_W  registered bank port row.
- pipe_vld  out  RPORT_NUM  registered granted-request valid.
- pipe_vaddr  out  RPORT_NUM*ADDR_W  registered address.
- pipe_rs_idx  out  RPORT_NUM*RS_W  registered tag.
- pipe_rs_field_idx  out  RPORT_NUM*2  registered field.
- pipe_bank  out  RPORT_NUM*2  bank that serves each port.
- pipe_slot  out  RPORT_NUM  bank read port (0/1) that serves each port.
- conflict_cnt  out  CNT_W  saturating count of cycles with at least one valid request denied.

Behaviour:
- Address mapping:
  - bank = {vaddr[5], vaddr[0]} (y = vreg[4], x = partial).
  - row = vaddr[4:1].
- Per bank, each cycle:
  - Scan the valid requests mapped to that bank starting at rr_ptr[bank] (0..4), wrapping modulo 5.
  - The first distinct row found takes slot 0; the second distinct row takes slot 1.
  - A later request whose row equals an already-slotted row is granted and shares that slot (merge).
  - Requests with a third or later distinct row are denied: req_rdy=0. The requester holds its request unchanged.
- req_rdy is combinational from req_vld/req_vaddr/rr_ptr in the same cycle. A port with req_vld=0 has req_rdy=0.
- rr_ptr update: if the bank slotted any row this cycle, rr_ptr = (port that took the last used slot + 1) mod 5. Otherwise rr_ptr holds. Merged grants do not move the pointer.
- Pipeline: grants in cycle N appear on pipe_* and bank_rd_* after the edge, i.e. in cycle N+1. Latency is 1. There is no backpressure on the pipe stage.
- Unused bank slots: bank_rd_en=0 and bank_rd_row holds its previous value. For ungranted ports, pipe_vld=0 and the other pipe fields are don't-care, but hold their previous values.
- flush:
  - In a flush cycle, all req_rdy=0 and no grants are made.
  - rr_ptr holds.
  - Next cycle, pipe_vld=0 and bank_rd_en=0.
  - Flush has priority over all requests.
- conflict_cnt increments when some req_vld has req_rdy=0 and flush=0. It saturates at all-ones.
- Reset (async, any time, including mid-operation):
  - rr_ptr=0.
  - pipe_* = 0 and bank_rd_* = 0.
  - conflict_cnt=0.
  - req_rdy is 0 while rst is high.
- No starvation: a continuously held request is granted within 3 cycles in its bank (at most 2 slots are taken per cycle before the pointer passes it).

Test Plan:
- Reset, then ports 0..4 read vaddr 0x00, 0x01, 0x20, 0x21, 0x02 (banks 0, 1, 2, 3, 0) -> all req_rdy=1; next cycle bank0 slots rows 0 and 1, banks 1/2/3 slot0 row 0; pipe_bank = {0, 1, 2, 3, 0}.
- Ports 0..4 read vaddr 0x00, 0x02, 0x04, 0x06, 0x08 (all bank0), rr_ptr=0 -> cycle 1 grants p0 and p1; rr_ptr=2; cycle 2 grants p2 and p3; cycle 3 grants p4; conflict_cnt = 2.
- Ports 0..4 all read vaddr 0x0A -> all granted in 1 cycle on bank0 slot0 (row 5); bank_rd_en[bank0 slot1]=0; rr_ptr[0]=1.
- Ports 0..2 read vaddr 0x00, 0x02, 0x00 with rr_ptr=0 -> p0 and p2 merge on slot0, p1 on slot1; all req_rdy=1.
- Contended bank0 traffic with flush=1 in cycle 2 -> req_rdy=0 in cycle 2; pipe_vld=0 in cycle 3; rr_ptr unchanged; conflict_cnt unchanged in cycle 2.
- Assert rst mid-stream with pending grants -> pipe_vld, bank_rd_en and conflict_cnt go to 0 immediately (asynchronously); after release, the first grant scans from port 0.
